// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multi-cycle CPU. It sequences the shared ALU, memory,
//   IR, PC and register file through the fetch, decode, execute, memory and writeback states.
// Latency: MEM_LAT cycles per memory state (FETCH, MEMRD, MEMWR), 1 cycle per other state.
//   lw 3+2L, sw 2+2L, R/addi 3+L, beq/j 2+L, unknown opcode 1+L.
// Backpressure: none. All outputs are decoded combinationally from the current state, with
//   funct used in EXEC/ALUWB and zero used in BRANCH. rst forces all write strobes low.
// Ports: clk, rst (sync, active-high), opcode/funct (from IR), zero (ALU flag) ->
//   pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//   alu_src_b[1:0], pc_src[1:0], alu_ctrl[2:0], state[3:0] (debug).
module multi_cycle_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_BAD = 3'b111;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] wait_cnt;
  logic       held_state;
  logic       wait_done;

  // R-type function decode, shared by EXEC (alu_ctrl) and ALUWB (write enable)
  logic [2:0] r_alu;
  logic       r_ok;

  // Strobes before the reset gate
  logic pc_en_c, mem_write_c, ir_write_c, reg_write_c;

  assign held_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
  assign wait_done  = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      // Counts only while parked in a memory state; any exit leaves it cleared
      if (held_state && !wait_done)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    r_alu = ALU_BAD;
    r_ok  = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state   = S_FETCH;
    pc_en_c     = 1'b0;
    iord        = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_ctrl    = ALU_ADD;

    case (cur_state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        // IR and PC load once, on the final cycle of the memory access
        if (wait_done) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          nxt_state  = S_DECODE;
        end else begin
          nxt_state  = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculative branch target: PC + (imm << 2)
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      nxt_state = S_EXEC;
          OP_LW, OP_SW:  nxt_state = S_MEMADR;
          OP_BEQ:        nxt_state = S_BRANCH;
          OP_ADDI:       nxt_state = S_ADDI_EX;
          OP_J:          nxt_state = S_JUMP;
          default:       nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        nxt_state = wait_done ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        nxt_state   = wait_done ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        nxt_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = r_ok;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en_c   = zero;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en_c = 1'b1;
      end
      default: begin
        // Unused encodings recover to FETCH with everything at default
        nxt_state = S_FETCH;
      end
    endcase
  end

  // A mid-instruction reset abandons the instruction without touching architectural state
  assign pc_en     = pc_en_c     & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;
  assign state     = cur_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: three instances with MEM_LAT = 1, 2, 3 each run directed and
// random instruction streams. Per instruction, an expected per-cycle output list is built from
// the instruction-level rules and compared with the DUT on every falling edge.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       a;
    logic [1:0] b;
    logic [1:0] pc_src;
    logic [2:0] alu;
  } exp_t;

  logic       clk;
  logic       rst_v    [3];
  logic [5:0] op_v     [3];
  logic [5:0] fn_v     [3];
  logic       zero_v   [3];
  exp_t       act      [3];
  exp_t       cur_exp  [3];
  exp_t       cur_mask [3];
  logic       cur_vld  [3];
  exp_t       seqq     [3][$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    multi_cycle_ctrl #(.MEM_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .opcode     (op_v[g]),
      .funct      (fn_v[g]),
      .zero       (zero_v[g]),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_ctrl   (alu_ctrl),
      .state      (state)
    );

    assign act[g] = {state, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl};
  end

  // Single compare process: every valid cycle of every instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cur_vld[k]) begin
        checks++;
        if (((act[k] ^ cur_exp[k]) & cur_mask[k]) !== '0) begin
          errors++;
          $display("FAIL outputs L=%0d t=%0t: got %b, expected %b (mask %b)",
                   k + 1, $time, act[k], cur_exp[k], cur_mask[k]);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.alu = 3'b100;
    return e;
  endfunction

  function automatic exp_t strobe_mask();
    exp_t m;
    m           = '0;
    m.pc_en     = 1'b1;
    m.mem_write = 1'b1;
    m.ir_write  = 1'b1;
    m.reg_write = 1'b1;
    return m;
  endfunction

  // Instruction-level model: the list of cycles an instruction occupies and what each drives
  task automatic build(input int k, input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    int   lat;
    lat = k + 1;
    seqq[k].delete();
    for (int c = 0; c < lat; c++) begin
      e   = mk(4'd0);
      e.b = 2'b01;
      if (c == lat - 1) begin
        e.ir_write = 1'b1;
        e.pc_en    = 1'b1;
      end
      seqq[k].push_back(e);
    end
    e = mk(4'd1); e.b = 2'b11; seqq[k].push_back(e);
    case (op)
      6'b000000: begin
        e = mk(4'd6); e.a = 1'b1;
        case (fn)
          6'b100000: e.alu = 3'b100;
          6'b100010: e.alu = 3'b110;
          6'b100100: e.alu = 3'b000;
          6'b100101: e.alu = 3'b001;
          6'b101010: e.alu = 3'b011;
          default:   e.alu = 3'b111;
        endcase
        seqq[k].push_back(e);
        e = mk(4'd7); e.reg_dst = 1'b1;
        e.reg_write = (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
        seqq[k].push_back(e);
      end
      6'b100011, 6'b101011: begin
        e = mk(4'd2); e.a = 1'b1; e.b = 2'b10; seqq[k].push_back(e);
        for (int c = 0; c < lat; c++) begin
          if (op == 6'b100011) begin
            e = mk(4'd3); e.iord = 1'b1;
          end else begin
            e = mk(4'd5); e.iord = 1'b1; e.mem_write = 1'b1;
          end
          seqq[k].push_back(e);
        end
        if (op == 6'b100011) begin
          e = mk(4'd4); e.mem_to_reg = 1'b1; e.reg_write = 1'b1; seqq[k].push_back(e);
        end
      end
      6'b000100: begin
        e = mk(4'd8); e.a = 1'b1; e.alu = 3'b110; e.pc_src = 2'b01; seqq[k].push_back(e);
      end
      6'b001000: begin
        e = mk(4'd9); e.a = 1'b1; e.b = 2'b10; seqq[k].push_back(e);
        e = mk(4'd10); e.reg_write = 1'b1; seqq[k].push_back(e);
      end
      6'b000010: begin
        e = mk(4'd11); e.pc_src = 2'b10; e.pc_en = 1'b1; seqq[k].push_back(e);
      end
      default: ;
    endcase
  endtask

  // zmode: 0 random zero, 1 zero=1, 2 zero=0. abort_at: cycle index to pulse rst (-1 none).
  // exp_len: hand-computed instruction length (-1 skip).
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at, input int exp_len);
    exp_t e;
    logic z;
    build(k, op, fn);
    if (exp_len >= 0) begin
      checks++;
      if (seqq[k].size() != exp_len) begin
        errors++;
        $display("FAIL length L=%0d op=%b: model %0d cycles, expected %0d",
                 k + 1, op, seqq[k].size(), exp_len);
      end
    end
    for (int i = 0; i < seqq[k].size(); i++) begin
      e = seqq[k][i];
      if (zmode == 1)      z = 1'b1;
      else if (zmode == 2) z = 1'b0;
      else                 z = 1'($urandom_range(0, 1));
      rst_v[k]  = (i == abort_at);
      zero_v[k] = z;
      // IR only needs to be stable where the controller reads it; elsewhere drive junk
      if (e.st inside {4'd1, 4'd2, 4'd6, 4'd7}) begin
        op_v[k] = op;
        fn_v[k] = fn;
      end else begin
        op_v[k] = 6'($urandom);
        fn_v[k] = 6'($urandom);
      end
      if (e.st == 4'd8) e.pc_en = z;
      if (rst_v[k]) begin
        e.pc_en = 1'b0; e.mem_write = 1'b0; e.ir_write = 1'b0; e.reg_write = 1'b0;
      end
      cur_exp[k]  = e;
      cur_mask[k] = '1;
      cur_vld[k]  = 1'b1;
      @(posedge clk); #1;
      if (i == abort_at) break;
    end
    rst_v[k] = 1'b0;
  endtask

  task automatic do_reset(input int k);
    exp_t m;
    rst_v[k]  = 1'b1;
    op_v[k]   = '0;
    fn_v[k]   = '0;
    zero_v[k] = 1'b0;
    cur_exp[k]  = mk(4'd0);
    cur_mask[k] = strobe_mask();
    cur_vld[k]  = 1'b1;
    @(posedge clk); #1;
    m    = strobe_mask();
    m.st = 4'hF;
    cur_mask[k] = m;
    @(posedge clk); #1;
    rst_v[k] = 1'b0;
  endtask

  task automatic run(input int k);
    logic [5:0] op, fn;
    int         sel, ab;
    do_reset(k);
    if (k == 0) begin
      run_instr(k, 6'b000000, 6'b100010, 0, -1, 4);
      run_instr(k, 6'b000100, 6'b000000, 1, -1, 3);
      run_instr(k, 6'b000100, 6'b000000, 2, -1, 3);
      run_instr(k, 6'b111111, 6'b000000, 0, -1, 2);
      run_instr(k, 6'b000000, 6'b000000, 0, -1, 4);
      run_instr(k, 6'b000010, 6'b000000, 0, -1, 3);
    end else if (k == 1) begin
      // reset lands in the first MEMWR cycle of sw
      run_instr(k, 6'b101011, 6'b000000, 0, 4, 6);
      run_instr(k, 6'b000010, 6'b000000, 0, -1, 4);
      run_instr(k, 6'b001000, 6'b000000, 0, -1, 5);
    end else begin
      run_instr(k, 6'b100011, 6'b000000, 0, -1, 9);
      run_instr(k, 6'b101011, 6'b000000, 0, -1, 8);
      run_instr(k, 6'b001000, 6'b000000, 0, -1, 6);
    end
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       op = 6'b000000;
        1:       op = 6'b100011;
        2:       op = 6'b101011;
        3:       op = 6'b000100;
        4:       op = 6'b001000;
        5:       op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       fn = 6'b100000;
        1:       fn = 6'b100010;
        2:       fn = 6'b100100;
        3:       fn = 6'b100101;
        4:       fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : -1;
      run_instr(k, op, fn, 0, ab, -1);
    end
    cur_vld[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cur_vld[k] = 1'b0;
      rst_v[k]   = 1'b1;
    end
    fork
      run(0);
      run(1);
      run(2);
    join
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
